// File: rtl/esprockell_out_port_tx.sv
// esprockell_out_port_tx: byte FIFO between the processor output port and an 8N1 UART transmitter.
// Latency: a write accepted into an empty FIFO with the line idle drives the start bit one cycle later.
// Backpressure: full_o stalls the processor; a write arriving while no slot is free is dropped and flagged on overflow_o.
module esprockell_out_port_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic               system1000,
  input  logic               system1000_rstn,
  input  logic               oen_i,
  input  logic signed [15:0] odata_i,
  output logic               full_o,
  output logic               busy_o,
  output logic               overflow_o,
  output logic               txd_o
);

  localparam int            AW        = $clog2(FIFO_DEPTH);
  localparam int            CW        = AW + 1;
  localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);
  localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [15:0]   baud;
  logic [15:0]   baud_nxt;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_nxt;
  logic [2:0]    bit_inc;
  logic [7:0]    shift;
  logic          baud_wrap;
  logic          txd_nxt;
  logic          pop;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          full_nxt;
  logic          busy_nxt;
  logic          ovf_nxt;

  // Only the low byte of the port value is ever sent; the upper byte is deliberately ignored.
  logic          unused_hi;
  assign unused_hi = ^odata_i[15:8];

  assign baud_wrap = (baud == BAUD_LAST);
  assign bit_inc   = bit_idx + 3'd1;

  // Transmit FSM: next state, baud/bit counters, next line level and the FIFO pop request.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud;
    bit_nxt   = bit_idx;
    txd_nxt   = txd_o;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        txd_nxt = 1'b1;
        if (count != '0) begin
          pop       = 1'b1;
          baud_nxt  = 16'd0;
          state_nxt = START;
          txd_nxt   = 1'b0;
        end
      end
      START: begin
        if (baud_wrap) begin
          baud_nxt  = 16'd0;
          bit_nxt   = 3'd0;
          state_nxt = DATA;
          txd_nxt   = shift[0];
        end else begin
          baud_nxt = baud + 16'd1;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_nxt = 16'd0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            txd_nxt   = 1'b1;
          end else begin
            bit_nxt = bit_inc;
            txd_nxt = shift[bit_inc];
          end
        end else begin
          baud_nxt = baud + 16'd1;
        end
      end
      STOP: begin
        // Returning to IDLE costs one cycle before the next pop, giving a 10*CLKS_PER_BIT+1 frame period.
        if (baud_wrap) begin
          baud_nxt  = 16'd0;
          state_nxt = IDLE;
          txd_nxt   = 1'b1;
        end else begin
          baud_nxt = baud + 16'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        baud_nxt  = 16'd0;
        txd_nxt   = 1'b1;
      end
    endcase
  end

  // FIFO occupancy and registered status flags; a pop in the same cycle frees a slot for a write into a full FIFO.
  always_comb begin
    push      = oen_i && ((count != DEPTH) || pop);
    ovf_nxt   = oen_i && !push;
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
    full_nxt = (count_nxt == DEPTH);
    busy_nxt = (count_nxt != '0) || (state_nxt != IDLE);
  end

  // Transmitter registers; reset aborts any frame and returns the line high.
  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      state   <= IDLE;
      baud    <= 16'd0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      txd_o   <= 1'b1;
    end else begin
      state   <= state_nxt;
      baud    <= baud_nxt;
      bit_idx <= bit_nxt;
      txd_o   <= txd_nxt;
      if (pop) begin
        shift <= mem[rd_ptr];
      end
    end
  end

  // FIFO pointers, count and status outputs; pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full_o     <= 1'b0;
      busy_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count      <= count_nxt;
      full_o     <= full_nxt;
      busy_o     <= busy_nxt;
      overflow_o <= ovf_nxt;
    end
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge system1000) begin
    if (system1000_rstn && push) begin
      mem[wr_ptr] <= odata_i[7:0];
    end
  end

endmodule
